// File: rtl/data_mem_pkg.sv
// Shared pipeline definitions: memory-stage opcodes, clear/ready state encoding,
// and opcode classification helpers.
package data_mem_pkg;

   localparam int unsigned OP_W = 6;

   localparam logic [OP_W-1:0] LW  = 6'h23;
   localparam logic [OP_W-1:0] LB  = 6'h20;
   localparam logic [OP_W-1:0] LBU = 6'h24;
   localparam logic [OP_W-1:0] LH  = 6'h21;
   localparam logic [OP_W-1:0] LHU = 6'h25;
   localparam logic [OP_W-1:0] SW  = 6'h2B;
   localparam logic [OP_W-1:0] SB  = 6'h28;
   localparam logic [OP_W-1:0] SH  = 6'h29;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } mem_state_t;

   function automatic logic is_load(input logic [OP_W-1:0] op);
      return op inside {LW, LB, LBU, LH, LHU};
   endfunction

   function automatic logic is_store(input logic [OP_W-1:0] op);
      return op inside {SW, SB, SH};
   endfunction

   function automatic logic is_word_op(input logic [OP_W-1:0] op);
      return op inside {LW, SW};
   endfunction

   function automatic logic is_half_op(input logic [OP_W-1:0] op);
      return op inside {LH, LHU, SH};
   endfunction

endpackage

// File: rtl/data_mem_load_ext.sv
// Picks the addressed byte/halfword out of a loaded word and extends it;
// non-load opcodes yield zero.
module load_ext
   import data_mem_pkg::*;
(
   input  logic [OP_W-1:0] opcode,
   input  logic [1:0]      byte_off,
   input  logic [31:0]     word,
   output logic [31:0]     result
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      sel_byte = word[{byte_off, 3'b000} +: 8];
      sel_half = byte_off[1] ? word[31:16] : word[15:0];
      result   = '0;
      case (opcode)
         LW:      result = word;
         LB:      result = {{24{sel_byte[7]}}, sel_byte};
         LBU:     result = {24'h0, sel_byte};
         LH:      result = {{16{sel_half[15]}}, sel_half};
         LHU:     result = {16'h0, sel_half};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/data_mem.sv
// Memory-stage data RAM: byte-lane stores, combinational extended loads, and a
// self-clear sweep after reset during which the pipeline is held via busy.
module data_mem
   import data_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Instr_M,
   input  logic [31:0] ALU_M,
   input  logic [31:0] WD_M,
   output logic [31:0] N_DM_W,
   output logic        busy,
   output logic        addr_err
);

   localparam int unsigned PTR_W = $clog2(DEPTH_WORDS);

   logic [31:0]      mem [0:DEPTH_WORDS-1];
   mem_state_t       state;
   logic [PTR_W-1:0] ptr;

   logic [OP_W-1:0]  opcode;
   logic [PTR_W-1:0] word_idx;
   logic             out_of_range;
   logic             misaligned;
   logic             access;
   logic             store_en;
   logic [3:0]       byte_we;
   logic [31:0]      wdata;
   logic [31:0]      ext_result;
   logic             unused_instr;

   assign opcode       = Instr_M[31:26];
   assign unused_instr = ^Instr_M[25:0];
   assign word_idx     = ALU_M[PTR_W+1:2];
   assign out_of_range = {2'b00, ALU_M[31:2]} >= 32'(DEPTH_WORDS);
   assign misaligned   = (is_word_op(opcode) && (ALU_M[1:0] != 2'b00))
                       || (is_half_op(opcode) && ALU_M[0]);
   assign access       = is_load(opcode) || is_store(opcode);
   assign addr_err     = access && (misaligned || out_of_range);
   assign busy         = (state == CLEAR);
   assign store_en     = is_store(opcode) && !addr_err && (state == READY) && !rst;

   // Lane enables and lane-replicated store data
   always_comb begin
      byte_we = '0;
      wdata   = WD_M;
      case (opcode)
         SW: byte_we = 4'b1111;
         SH: begin
            byte_we = ALU_M[1] ? 4'b1100 : 4'b0011;
            wdata   = {2{WD_M[15:0]}};
         end
         SB: begin
            byte_we = 4'b0001 << ALU_M[1:0];
            wdata   = {4{WD_M[7:0]}};
         end
         default: byte_we = '0;
      endcase
   end

   // Clear sweep: one word per cycle, stops on the last word without wrapping
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         case (state)
            CLEAR: begin
               if (ptr == PTR_W'(DEPTH_WORDS - 1)) begin
                  state <= READY;
               end else begin
                  ptr <= ptr + PTR_W'(1);
               end
            end
            default: state <= READY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && (state == CLEAR)) begin
         mem[ptr] <= '0;
      end else if (store_en) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (byte_we[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   load_ext u_load_ext (
      .opcode   (opcode),
      .byte_off (ALU_M[1:0]),
      .word     (mem[word_idx]),
      .result   (ext_result)
   );

   assign N_DM_W = (busy || addr_err || !is_load(opcode)) ? 32'h0 : ext_result;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed and random accesses compared
// against a byte-array model of the 4 KiB memory.
module tb_data_mem;

   localparam logic [5:0] T_LW = 6'h23, T_LB = 6'h20, T_LBU = 6'h24, T_LH = 6'h21;
   localparam logic [5:0] T_LHU = 6'h25, T_SW = 6'h2B, T_SB = 6'h28, T_SH = 6'h29;
   localparam int unsigned BYTES = 4096;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] Instr_M;
   logic [31:0] ALU_M;
   logic [31:0] WD_M;
   logic [31:0] N_DM_W;
   logic        busy;
   logic        addr_err;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  ref_mem [0:BYTES-1];
   logic [5:0]  op_tab [0:9];

   data_mem #(.DEPTH_WORDS(1024)) dut (
      .clk      (clk),
      .rst      (rst),
      .Instr_M  (Instr_M),
      .ALU_M    (ALU_M),
      .WD_M     (WD_M),
      .N_DM_W   (N_DM_W),
      .busy     (busy),
      .addr_err (addr_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic m_is_load(input logic [5:0] op);
      return (op == T_LW) || (op == T_LB) || (op == T_LBU) || (op == T_LH) || (op == T_LHU);
   endfunction

   function automatic logic m_is_store(input logic [5:0] op);
      return (op == T_SW) || (op == T_SB) || (op == T_SH);
   endfunction

   // Access size in bytes for alignment purposes
   function automatic int m_size(input logic [5:0] op);
      if (op == T_LW || op == T_SW) return 4;
      if (op == T_LH || op == T_LHU || op == T_SH) return 2;
      return 1;
   endfunction

   function automatic logic m_err(input logic [5:0] op, input logic [31:0] a);
      if (!m_is_load(op) && !m_is_store(op)) return 1'b0;
      if (a >= BYTES) return 1'b1;
      return (a % m_size(op)) != 0;
   endfunction

   function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a);
      logic [31:0] v;
      if (!m_is_load(op) || m_err(op, a)) return 32'h0;
      case (op)
         T_LW:  v = ref_mem[a] + (ref_mem[a+1] * 32'd256) + (ref_mem[a+2] * 32'd65536)
                  + (ref_mem[a+3] * 32'd16777216);
         T_LB:  begin v = 32'(ref_mem[a]); if (v >= 128) v = v - 32'd256; end
         T_LBU: v = 32'(ref_mem[a]);
         T_LH:  begin v = ref_mem[a] + ref_mem[a+1] * 32'd256; if (v >= 32768) v = v - 32'd65536; end
         default: v = ref_mem[a] + ref_mem[a+1] * 32'd256;
      endcase
      return v;
   endfunction

   task automatic m_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
      if (!m_is_store(op) || m_err(op, a)) return;
      for (int i = 0; i < m_size(op); i++) ref_mem[a+i] = 8'((d >> (8*i)) & 32'hFF);
   endtask

   task automatic m_clear();
      for (int i = 0; i < int'(BYTES); i++) ref_mem[i] = 8'h00;
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One READY-state access: check combinational outputs, then commit on the edge
   task automatic access(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] d);
      Instr_M = {op, 26'($urandom)};
      ALU_M   = a;
      WD_M    = d;
      #1;
      chk1({tag, ".addr_err"}, addr_err, m_err(op, a));
      chk32({tag, ".rd"}, N_DM_W, m_load(op, a));
      @(posedge clk);
      m_store(op, a, d);
      #1;
   endtask

   // Run while busy (up to limit cycles), presenting loads/stores that must be ignored
   task automatic clear_phase(input int limit, output int cyc);
      cyc = 0;
      while (busy === 1'b1 && cyc < limit) begin
         Instr_M = {(cyc % 2 == 0) ? T_SW : T_LW, 26'($urandom)};
         ALU_M   = {20'h0, 10'($urandom), 2'b00};
         WD_M    = $urandom | 32'h1;
         #1;
         if (cyc % 64 == 1) chk32("clear.rd_zero", N_DM_W, 32'h0);
         cyc++;
         tick();
      end
   endtask

   initial begin
      int cyc;
      logic [5:0]  op;
      logic [31:0] a;
      op_tab = '{T_LW, T_LB, T_LBU, T_LH, T_LHU, T_SW, T_SB, T_SH, 6'h00, 6'h2A};
      rst = 1'b1; Instr_M = '0; ALU_M = '0; WD_M = '0;
      tick();
      rst = 1'b0;
      Instr_M = {T_LW, 26'h0};
      #1;
      chk1("reset.busy", busy, 1'b1);
      chk32("reset.rd", N_DM_W, 32'h0);
      ALU_M = 32'h2;
      #1;
      chk1("reset.addr_err_follows", addr_err, 1'b1);

      clear_phase(2000, cyc);
      n_checks++;
      assert (cyc == 1024) else begin
         n_fail++;
         $error("FAIL clear.length: observed %0d expected %0d", cyc, 1024);
      end
      m_clear();
      chk1("ready.busy", busy, 1'b0);
      access("first_lw_top", T_LW, 32'h0FFC, 32'h0);

      access("sw10", T_SW, 32'h10, 32'h12345678);
      access("lb13", T_LB, 32'h13, 32'h0);
      access("lh10", T_LH, 32'h10, 32'h0);
      access("lbu11", T_LBU, 32'h11, 32'h0);
      chk32("lbu11.const", m_load(T_LBU, 32'h11), 32'h00000056);

      access("sw20", T_SW, 32'h20, 32'h000080FF);
      access("lb20", T_LB, 32'h20, 32'h0);
      access("lbu20", T_LBU, 32'h20, 32'h0);
      access("lh20", T_LH, 32'h20, 32'h0);
      access("lhu20", T_LHU, 32'h20, 32'h0);
      chk32("lh20.const", m_load(T_LH, 32'h20), 32'hFFFF80FF);

      access("sw30", T_SW, 32'h30, 32'hAAAAAAAA);
      access("sb31", T_SB, 32'h31, 32'h55);
      access("lw30a", T_LW, 32'h30, 32'h0);
      access("sh32", T_SH, 32'h32, 32'h1234);
      access("lw30b", T_LW, 32'h30, 32'h0);
      chk32("lw30b.const", m_load(T_LW, 32'h30), 32'h123455AA);

      access("sw22_mis", T_SW, 32'h22, 32'hFFFFFFFF);
      access("lh21_mis", T_LH, 32'h21, 32'h0);
      access("sw1000_oor", T_SW, 32'h1000, 32'hFFFFFFFF);
      access("lw1000_oor", T_LW, 32'h1000, 32'h0);
      access("lw20_kept", T_LW, 32'h20, 32'h0);
      access("lw0_kept", T_LW, 32'h0, 32'h0);

      for (int i = 0; i < 400; i++) begin
         op = op_tab[$urandom_range(0, 9)];
         case ($urandom_range(0, 7))
            0:       a = 32'($urandom);
            1, 2:    a = $urandom_range(0, 4095);
            default: a = $urandom_range(0, 63);
         endcase
         access("rand", op, a, $urandom);
      end

      access("sw0", T_SW, 32'h0, 32'hDEADBEEF);
      access("lw0", T_LW, 32'h0, 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_phase(500, cyc);
      chk1("midclear.busy", busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_phase(2000, cyc);
      n_checks++;
      assert (cyc == 1024) else begin
         n_fail++;
         $error("FAIL reclear.length: observed %0d expected %0d", cyc, 1024);
      end
      m_clear();
      access("lw0_after", T_LW, 32'h0, 32'h0);
      access("lw_top_after", T_LW, 32'h0FFC, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
